// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file: default geometry and the
// hard-wired zero register index.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    // Index of the register that always reads zero and ignores writes.
    localparam int ZERO_IDX   = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register. A set and a clear
// to the same index in one cycle leave the flag set.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr,
    input  logic [ADDR_W-1:0]        clr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] busy_q;

    // Clear is applied before set, which is what makes set win on a collision.
    always_comb begin
        busy_d = busy_q;
        if (clr && (clr_addr != ADDR_W'(ZERO_IDX))) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set && (set_addr != ADDR_W'(ZERO_IDX))) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : reg_file_scoreboard

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a pending-write scoreboard and a
// hard-wired zero register. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_fire;

    assign wr_fire = wr_en && (wr_addr != ADDR_W'(ZERO_IDX));

    always_comb begin
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set      (sb_set),
        .set_addr (sb_addr),
        .clr      (wr_en),
        .clr_addr (wr_addr),
        .busy     (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] stored;

        assign idx    = rd_addr[k*ADDR_W +: ADDR_W];
        assign stored = (idx == ADDR_W'(ZERO_IDX)) ? '0 : regs_q[idx];

`ifdef REG_FILE_BYPASS_EN
        // A write held off by reset is discarded, so it must not bypass either.
        logic hit;
        assign hit = !rst && wr_fire && (idx == wr_addr);
        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : stored;
        assign rd_busy[k] = hit ? (sb_set && (sb_addr == wr_addr)) : busy[idx];
`else
        assign rd_data[k*DATA_W +: DATA_W] = stored;
        assign rd_busy[k] = busy[idx];
`endif
    end

endmodule : reg_file_mp

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, register index width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 Port clk  in  1  clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port rd_addr  in  NUM_RD*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 Port rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
REQ-008 Port rd_busy  out  NUM_RD  per-port scoreboard flag: addressed register has a pending write.
REQ-009 Port wr_en  in  1  write strobe.
REQ-010 Port wr_addr  in  ADDR_W  write index.
REQ-011 Port wr_data  in  DATA_W  write data.
REQ-012 Port sb_set  in  1  mark register sb_addr pending (long-latency result issued).
REQ-013 Port sb_addr  in  ADDR_W  index to mark pending.

Function
REQ-014 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]], zero latency, all ports independent, same address on several ports allowed.
REQ-015 Register 0 SHALL read as 0 always; writes to index 0 SHALL be ignored.
REQ-016 wr_en=1, wr_addr!=0 SHALL update reg[wr_addr] with wr_data at the rising edge.
REQ-017 Scoreboard: one busy bit per register; sb_set=1, sb_addr!=0 SHALL set busy[sb_addr] at the edge.
REQ-018 wr_en=1, wr_addr!=0 SHALL clear busy[wr_addr] at the same edge as the data update.
REQ-019 Simultaneous sb_set and write to the same index SHALL leave busy=1 (set wins) and store wr_data.
REQ-020 sb_set on an already-busy register SHALL keep it busy; a write to a non-busy register SHALL be legal and leave it clear.
REQ-021 busy[0] SHALL be constant 0; rd_busy[k] = busy[rd_addr[k]].
REQ-022 Write and set to different indices in one cycle SHALL both take effect.

Reset
REQ-023 rst=1 SHALL asynchronously clear every register and every busy bit, including mid-write; rd_data and rd_busy SHALL then read all zeros.
REQ-024 Writes and sets presented while rst=1 SHALL be discarded.
REQ-025 Deassertion SHALL need no further initialisation; first write accepted on the first edge with rst=0.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN defined: a read port whose index equals wr_addr while wr_en=1 and wr_addr!=0 SHALL return wr_data the same cycle, and its rd_busy SHALL show the post-edge value (0, unless sb_set targets the same index).
REQ-027 Macro undefined: reads SHALL return the pre-edge register and busy values; new data visible from the next cycle.

Structure
REQ-028 Shared package reg_file_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the zero-register index constant.
REQ-029 Busy-bit logic SHALL live in sub-module reg_file_scoreboard (ports clk, rst, set, set_addr, clr, clr_addr, busy vector); storage and read muxes stay in reg_file_mp.

Verification
REQ-030 Reset: write 0xDEADBEEF to r5, pulse rst -> rd_data(r5)=0, rd_busy=0 on all ports.
REQ-031 Zero register: write 0x12345678 to r0, sb_set r0 -> r0 reads 0, rd_busy=0.
REQ-032 Multi-port: write r3=0xA, r7=0xB; read r3, r7, r3 on three ports (NUM_RD=3) -> 0xA, 0xB, 0xA.
REQ-033 Scoreboard: sb_set r9 -> rd_busy=1 next cycle; write r9=0x55 -> busy 0 and data 0x55 after edge; same-cycle set+write r9 -> busy stays 1, data stored.
REQ-034 Bypass: read r4 while writing r4=0xCAFE -> 0xCAFE same cycle with REG_FILE_BYPASS_EN, old value without it.
REQ-035 Async reset mid-operation: assert rst between edges during wr_en=1 to r2 -> r2 reads 0 immediately and after the next edge.
